// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade engine: waveform mode encodings and
// triangle direction values.
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_TRI   = 2'b01,
        MODE_SAWUP = 2'b10,
        MODE_SAWDN = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/fade_channel.sv
// One fade channel: level/direction registers, waveform step arithmetic with
// load priority, and the registered PWM compare.
module fade_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] pwm_cnt,
    output logic [WIDTH-1:0] lvl,
    output logic             pwm
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] lvl_reg, lvl_next;
    logic             dir_reg, dir_next;
    logic             pwm_reg;
    logic [WIDTH:0]   sum;

    // One extra bit so the triangle peak test cannot be fooled by wrap-around.
    assign sum = {1'b0, lvl_reg} + {1'b0, step};

    always_comb begin
        lvl_next = lvl_reg;
        dir_next = dir_reg;
        if (ld) begin
            lvl_next = ld_val;
            dir_next = DIR_UP;
        end else if (upd && (step != '0)) begin
            case (mode_e'(mode))
                MODE_TRI: begin
                    if (dir_reg == DIR_UP) begin
                        if (sum >= {1'b0, MAX}) begin
                            lvl_next = MAX;
                            dir_next = DIR_DOWN;
                        end else begin
                            lvl_next = sum[WIDTH-1:0];
                        end
                    end else begin
                        if (lvl_reg <= step) begin
                            lvl_next = '0;
                            dir_next = DIR_UP;
                        end else begin
                            lvl_next = lvl_reg - step;
                        end
                    end
                end
                MODE_SAWUP: lvl_next = lvl_reg + step;
                MODE_SAWDN: lvl_next = lvl_reg - step;
                default:    lvl_next = lvl_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_reg <= '0;
            dir_reg <= DIR_UP;
            pwm_reg <= 1'b0;
        end else begin
            lvl_reg <= lvl_next;
            dir_reg <= dir_next;
            pwm_reg <= (pwm_cnt < lvl_reg);
        end
    end

    assign lvl = lvl_reg;
    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_fade_engine.sv
// Multi-channel brightness fade generator: shared prescaler and PWM counter,
// load decode, and CH fade_channel instances packed onto the outputs.
module pwm_fade_engine
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 3,
    parameter int DIV   = 1000000,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1,
    localparam int PW   = $clog2(DIV)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    step,
    input  logic [CH-1:0]       ch_en,
    input  logic                load,
    input  logic [CHW-1:0]      load_ch,
    input  logic [WIDTH-1:0]    load_val,
    output logic [CH*WIDTH-1:0] level,
    output logic [CH-1:0]       pwm_out,
    output logic                tick
);

    logic [PW-1:0]    pcnt_reg;
    logic [WIDTH-1:0] pwm_cnt_reg;
    logic             tick_reg;
    logic             wrap;

    // Levels advance on the same edge that raises tick, so the new level and
    // the tick pulse appear together.
    assign wrap = en && (pcnt_reg == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg    <= '0;
            pwm_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            tick_reg    <= wrap;
            if (en) begin
                pcnt_reg <= wrap ? '0 : pcnt_reg + 1'b1;
            end
        end
    end

    assign tick = tick_reg;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic             ld_hit;
            logic [WIDTH-1:0] ch_lvl;
            logic             ch_pwm;

            // Out-of-range channel numbers match no instance and are dropped.
            assign ld_hit = load && (load_ch == CHW'(gi));

            fade_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .upd     (wrap && ch_en[gi]),
                .mode    (mode),
                .step    (step),
                .ld      (ld_hit),
                .ld_val  (load_val),
                .pwm_cnt (pwm_cnt_reg),
                .lvl     (ch_lvl),
                .pwm     (ch_pwm)
            );

            assign level[gi*WIDTH +: WIDTH] = ch_lvl;
            assign pwm_out[gi]              = ch_pwm;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_fade_engine.sv
// Directed self-checking bench for pwm_fade_engine with DIV=4, WIDTH=8, CH=3.
module tb_pwm_fade_engine;

    localparam int WIDTH = 8;
    localparam int CH    = 3;
    localparam int DIV   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [1:0]          mode;
    logic [WIDTH-1:0]    step;
    logic [CH-1:0]       ch_en;
    logic                load;
    logic [1:0]          load_ch;
    logic [WIDTH-1:0]    load_val;
    logic [CH*WIDTH-1:0] level;
    logic [CH-1:0]       pwm_out;
    logic                tick;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    pwm_fade_engine #(
        .WIDTH (WIDTH),
        .CH    (CH),
        .DIV   (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .step     (step),
        .ch_en    (ch_en),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
        .level    (level),
        .pwm_out  (pwm_out),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %-14s got %0d", tag, obs);
        end else begin
            $display("FAIL %-14s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge of the next tick-high cycle, bounded.
    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_to"}, 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [WIDTH-1:0] val);
        load     = 1'b1;
        load_ch  = ch;
        load_val = val;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Count pwm_out[ch] high cycles across one full PWM period.
    task automatic duty(input int ch, output int ones);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out[ch]) ones++;
        end
    endtask

    function automatic logic [31:0] lv(input int a2, input int a1, input int a0);
        logic [23:0] v;
        v = {a2[7:0], a1[7:0], a0[7:0]};
        return {8'd0, v};
    endfunction

    int tri_exp [7] = '{100, 200, 255, 155, 55, 0, 100};
    int n;
    int ticks;
    int d0, d1, d2;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; step = '0; ch_en = '0;
        load = 1'b0; load_ch = '0; load_val = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_tick", tick, 0);

        // Prescaler: tick on the 4th edge after enabling, then every 4.
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            repeat (3) begin
                @(negedge clk);
                check("pre_notick", tick, 0);
            end
            @(negedge clk);
            check("pre_tick", tick, 1);
            check("pre_level", level, 0);
            check("pre_pwm", pwm_out, 0);
        end

        // Triangle bounds.
        mode = 2'b01; step = 8'd100; ch_en = 3'b111;
        for (int k = 0; k < 7; k++) begin
            wait_tick("tri");
            check("tri_level", level, lv(tri_exp[k], tri_exp[k], tri_exp[k]));
        end

        // Sawtooth up wrap on ch1, others from 100.
        mode = 2'b10;
        do_load(2'd1, 8'd200);
        check("load_ch1", level, lv(100, 200, 100));
        wait_tick("sawup1");
        check("sawup_1", level, lv(200, 44, 200));
        wait_tick("sawup2");
        check("sawup_2", level, lv(44, 144, 44));

        // Sawtooth down wrap.
        mode = 2'b11; step = 8'd50;
        do_load(2'd0, 8'd20);
        check("load_ch0", level, lv(44, 144, 20));
        wait_tick("sawdn");
        check("sawdn", level, lv(250, 94, 226));

        // Triangle from mixed levels; ch0 and ch2 peak and turn down.
        mode = 2'b01;
        wait_tick("tri2");
        check("tri_peak", level, lv(255, 144, 255));

        // Load collides with a tick on ch0.
        repeat (3) @(negedge clk);
        do_load(2'd0, 8'd7);
        check("coll_tick", tick, 1);
        check("coll_level", level, lv(205, 194, 7));
        wait_tick("coll_dir");
        check("coll_dir", level, lv(155, 244, 57));

        do_load(2'd3, 8'd99);
        check("load_oob", level, lv(155, 244, 57));

        // Per-channel enable.
        ch_en = 3'b010;
        wait_tick("chen");
        check("ch_en_010", level, lv(155, 255, 57));

        // en=0: frozen, no tick, PWM still running.
        en = 1'b0;
        ticks = 0;
        d0 = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (tick) ticks++;
            if (pwm_out[0]) d0++;
            if (pwm_out[1]) d1++;
            if (pwm_out[2]) d2++;
        end
        check("en0_ticks", ticks, 0);
        check("en0_level", level, lv(155, 255, 57));
        check("en0_duty0", d0, 57);
        check("en0_duty1", d1, 255);
        check("en0_duty2", d2, 155);

        // step=0 behaves as hold.
        en = 1'b1; step = '0; ch_en = 3'b111;
        wait_tick("step0");
        check("step0_level", level, lv(155, 255, 57));

        // PWM duty on ch2.
        do_load(2'd2, 8'd64);
        duty(2, n);
        check("duty_64", n, 64);
        do_load(2'd2, 8'd0);
        duty(2, n);
        check("duty_0", n, 0);
        do_load(2'd2, 8'd255);
        duty(2, n);
        check("duty_255", n, 255);

        // Asynchronous reset mid-operation, observed between edges.
        #3 rst = 1'b1;
        #1;
        check("arst_level", level, 0);
        check("arst_pwm", pwm_out, 0);
        check("arst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
